// File: rtl/calc_sequencer.sv
// calc_sequencer: keypad-to-ALU sequencer for the calculator datapath.
// Builds multi-digit decimal operands from key presses, selects add/sub,
// handles memory save/recall and clear-entry, and strobes the ALU and
// memory blocks for one cycle whenever a value they consume changes.
// Optional build macro: CALC_OP_CHAIN_EN lets ADD/SUB after '=' reuse the
// ALU result as the next operand A.
module calc_sequencer #(
    parameter int WIDTH      = 8,
    parameter int MAX_DIGITS = 2
) (
    input  logic             Clock,
    input  logic             clearIn,
    input  logic             ready,
    input  logic [3:0]       tecla,
    input  logic [WIDTH-1:0] memoryIn,
    input  logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] memoryOut,
    output logic [WIDTH-1:0] numberA,
    output logic [WIDTH-1:0] numberB,
    output logic             operation,
    output logic             signedMemory,
    output logic             signedNumberA,
    output logic             signedNumberB,
    output logic             signedOperation,
    output logic             overflow,
    output logic             clearOut,
    output logic             readyOut,
    output logic [1:0]       estate
);

    typedef enum logic [1:0] {
        VALUE_A     = 2'b00,
        VALUE_B     = 2'b01,
        VALUE_IGUAL = 2'b10,
        VALUE_BAD   = 2'b11
    } state_t;

    localparam int             CW      = 3;
    localparam int             EW      = WIDTH + 4;
    localparam logic [CW-1:0]  MAX_CNT = CW'(MAX_DIGITS);
    localparam logic [EW-1:0]  MAX_VAL = {4'b0000, {WIDTH{1'b1}}};

    localparam logic [3:0] KEY_CE    = 4'hA;
    localparam logic [3:0] KEY_SUB   = 4'hB;
    localparam logic [3:0] KEY_ADD   = 4'hC;
    localparam logic [3:0] KEY_IGUAL = 4'hD;
    localparam logic [3:0] KEY_SAVE  = 4'hE;
    localparam logic [3:0] KEY_REC   = 4'hF;

    state_t           r_state, w_state;
    logic [WIDTH-1:0] r_a, w_a, r_b, w_b, r_mem, w_mem;
    logic [CW-1:0]    r_cnt_a, w_cnt_a, r_cnt_b, w_cnt_b;
    logic             r_op, w_op;
    logic             r_sa, w_sa, r_sb, w_sb, r_so, w_so, r_sm, w_sm;
    logic             r_ovf, w_ovf;
    logic             r_clear_out, r_ready_d, r_ready_d2;
    logic [3:0]       r_key;

    // Key is taken from registered ready/tecla so the action lands one
    // edge after the press is first seen; one action per rising edge.
    logic             w_accept;
    logic             w_is_digit;
    logic [WIDTH-1:0] w_cur;
    logic [CW-1:0]    w_cur_cnt;
    logic [EW-1:0]    w_cand;
    logic             w_digit_ok;

    assign w_accept   = r_ready_d & ~r_ready_d2;
    assign w_is_digit = (r_key <= 4'd9);
    assign w_cur      = (r_state == VALUE_B) ? r_b : r_a;
    assign w_cur_cnt  = (r_state == VALUE_B) ? r_cnt_b : r_cnt_a;
    // First digit replaces the operand; later digits shift it left in decimal.
    // The extra 4 bits keep value*10+d from wrapping before the range check.
    assign w_cand     = (w_cur_cnt == '0) ? EW'(r_key)
                                          : EW'(w_cur) * EW'(10) + EW'(r_key);
    assign w_digit_ok = (w_cur_cnt < MAX_CNT) && (w_cand <= MAX_VAL);

    // Next-state and next-output decode for one accepted key.
    always_comb begin
        // NOTE: every target gets a default first, so no path can leave a
        // value unassigned and infer a latch.
        w_state = r_state;
        w_a     = r_a;
        w_b     = r_b;
        w_mem   = r_mem;
        w_cnt_a = r_cnt_a;
        w_cnt_b = r_cnt_b;
        w_op    = r_op;
        w_sa    = 1'b0;
        w_sb    = 1'b0;
        w_so    = 1'b0;
        w_sm    = 1'b0;
        w_ovf   = 1'b0;
        if (r_state == VALUE_BAD) begin
            w_state = VALUE_A;
        end else if (w_accept) begin
            if (w_is_digit) begin
                if (r_state == VALUE_IGUAL) begin
                    w_a     = WIDTH'(r_key);
                    w_cnt_a = CW'(1);
                    w_b     = '0;
                    w_cnt_b = '0;
                    w_sa    = 1'b1;
                    w_sb    = 1'b1;
                    w_state = VALUE_A;
                end else if (!w_digit_ok) begin
                    w_ovf = 1'b1;
                end else if (r_state == VALUE_B) begin
                    w_b     = w_cand[WIDTH-1:0];
                    w_cnt_b = r_cnt_b + CW'(1);
                    w_sb    = 1'b1;
                end else begin
                    w_a     = w_cand[WIDTH-1:0];
                    w_cnt_a = r_cnt_a + CW'(1);
                    w_sa    = 1'b1;
                end
            end else begin
                case (r_key)
                    KEY_CE: begin
                        if (r_state == VALUE_A) begin
                            w_a = '0; w_cnt_a = '0; w_sa = 1'b1;
                        end else if (r_state == VALUE_B) begin
                            w_b = '0; w_cnt_b = '0; w_sb = 1'b1;
                        end
                    end
                    KEY_SAVE: begin
                        w_sm = 1'b1;
                        if (r_state == VALUE_A)      w_mem = r_a;
                        else if (r_state == VALUE_B) w_mem = r_b;
                        else                         w_mem = result;
                    end
                    KEY_REC: begin
                        if (r_state == VALUE_B) begin
                            w_b = memoryIn; w_cnt_b = MAX_CNT; w_sb = 1'b1;
                        end else begin
                            // Recalled value is locked against appended digits.
                            w_a = memoryIn; w_cnt_a = MAX_CNT; w_sa = 1'b1;
                            if (r_state == VALUE_IGUAL) begin
                                w_b = '0; w_cnt_b = '0; w_sb = 1'b1;
                                w_state = VALUE_A;
                            end
                        end
                    end
                    KEY_ADD, KEY_SUB: begin
                        if (r_state == VALUE_A) begin
                            w_op = (r_key == KEY_SUB); w_so = 1'b1;
                            w_b = '0; w_cnt_b = '0; w_sb = 1'b1;
                            w_state = VALUE_B;
                        end else if (r_state == VALUE_B) begin
                            w_op = (r_key == KEY_SUB); w_so = 1'b1;
                        end else begin
`ifdef CALC_OP_CHAIN_EN
                            w_a = result; w_cnt_a = MAX_CNT; w_sa = 1'b1;
                            w_op = (r_key == KEY_SUB); w_so = 1'b1;
                            w_b = '0; w_cnt_b = '0; w_sb = 1'b1;
                            w_state = VALUE_B;
`endif
                        end
                    end
                    KEY_IGUAL: begin
                        if (r_state == VALUE_B) w_state = VALUE_IGUAL;
                    end
                    default: ;
                endcase
            end
        end
    end

    // State, operand and strobe registers with synchronous reset.
    always_ff @(posedge Clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        r_clear_out <= clearIn;
        r_key       <= tecla;
        if (clearIn) begin
            r_state    <= VALUE_A;
            r_a        <= '0;
            r_b        <= '0;
            r_mem      <= '0;
            r_cnt_a    <= '0;
            r_cnt_b    <= '0;
            r_op       <= 1'b0;
            r_sa       <= 1'b0;
            r_sb       <= 1'b0;
            r_so       <= 1'b0;
            r_sm       <= 1'b0;
            r_ovf      <= 1'b0;
            r_ready_d  <= 1'b0;
            r_ready_d2 <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_a        <= w_a;
            r_b        <= w_b;
            r_mem      <= w_mem;
            r_cnt_a    <= w_cnt_a;
            r_cnt_b    <= w_cnt_b;
            r_op       <= w_op;
            r_sa       <= w_sa;
            r_sb       <= w_sb;
            r_so       <= w_so;
            r_sm       <= w_sm;
            r_ovf      <= w_ovf;
            r_ready_d  <= ready;
            r_ready_d2 <= r_ready_d;
        end
    end

    assign memoryOut       = r_mem;
    assign numberA         = r_a;
    assign numberB         = r_b;
    assign operation       = r_op;
    assign signedMemory    = r_sm;
    assign signedNumberA   = r_sa;
    assign signedNumberB   = r_sb;
    assign signedOperation = r_so;
    assign overflow        = r_ovf;
    assign clearOut        = r_clear_out;
    assign readyOut        = r_ready_d;
    assign estate          = r_state;

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: a table of key presses with expected outputs,
// plus hand-written sequences for held ready, wider digit limit, clear and
// strobe width. Expectations follow CALC_OP_CHAIN_EN when it is defined.
module tb_calc_sequencer;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] mem;
        logic       op;
        logic [1:0] st;
        logic       sa;
        logic       sb;
        logic       so;
        logic       sm;
        logic       ovf;
    } outs_t;

    typedef struct {
        bit         rst;
        logic [3:0] key;
        logic [7:0] mem_in;
        logic [7:0] res;
        outs_t      exp;
    } vec_t;

    logic       Clock = 1'b0;
    logic       clearIn = 1'b0;
    logic       ready = 1'b0;
    logic [3:0] tecla = 4'h0;
    logic [7:0] memoryIn = 8'h00;
    logic [7:0] result = 8'h00;

    logic [7:0] memoryOut, numberA, numberB;
    logic       operation, signedMemory, signedNumberA, signedNumberB;
    logic       signedOperation, overflow, clearOut, readyOut;
    logic [1:0] estate;

    logic [7:0] mo3, a3, b3;
    logic       op3, sm3, sa3, sb3, so3, ovf3, co3, ro3;
    logic [1:0] st3;

    int n_vec = 0;
    int n_bad = 0;
    vec_t vecs[$];

    always #5 Clock = ~Clock;

    calc_sequencer #(.WIDTH(8), .MAX_DIGITS(2)) u_dut (
        .Clock(Clock), .clearIn(clearIn), .ready(ready), .tecla(tecla),
        .memoryIn(memoryIn), .result(result), .memoryOut(memoryOut),
        .numberA(numberA), .numberB(numberB), .operation(operation),
        .signedMemory(signedMemory), .signedNumberA(signedNumberA),
        .signedNumberB(signedNumberB), .signedOperation(signedOperation),
        .overflow(overflow), .clearOut(clearOut), .readyOut(readyOut),
        .estate(estate)
    );

    calc_sequencer #(.WIDTH(8), .MAX_DIGITS(3)) u_dut3 (
        .Clock(Clock), .clearIn(clearIn), .ready(ready), .tecla(tecla),
        .memoryIn(memoryIn), .result(result), .memoryOut(mo3),
        .numberA(a3), .numberB(b3), .operation(op3),
        .signedMemory(sm3), .signedNumberA(sa3),
        .signedNumberB(sb3), .signedOperation(so3),
        .overflow(ovf3), .clearOut(co3), .readyOut(ro3),
        .estate(st3)
    );

    function automatic outs_t observe();
        outs_t o;
        o = '{a: numberA, b: numberB, mem: memoryOut, op: operation, st: estate,
              sa: signedNumberA, sb: signedNumberB, so: signedOperation,
              sm: signedMemory, ovf: overflow};
        return o;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void add(input bit rst, input logic [3:0] key,
                                input logic [7:0] mem_in, input logic [7:0] res,
                                input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] mem, input logic op,
                                input logic [1:0] st, input logic [4:0] strobes);
        vec_t v;
        v.rst = rst; v.key = key; v.mem_in = mem_in; v.res = res;
        v.exp = '{a: a, b: b, mem: mem, op: op, st: st, sa: strobes[4],
                  sb: strobes[3], so: strobes[2], sm: strobes[1], ovf: strobes[0]};
        vecs.push_back(v);
    endfunction

    task automatic do_reset();
        @(negedge Clock);
        clearIn = 1'b1;
        ready   = 1'b0;
        @(negedge Clock);
        clearIn = 1'b0;
    endtask

    // One key press: ready high for two edges, outputs sampled after the
    // action edge, then ready released for one edge.
    task automatic press(input logic [3:0] k, output outs_t o,
                         output logic [7:0] a_w, output logic ovf_w);
        @(negedge Clock);
        ready = 1'b1;
        tecla = k;
        @(negedge Clock);
        @(negedge Clock);
        o     = observe();
        a_w   = a3;
        ovf_w = ovf3;
        ready = 1'b0;
        @(negedge Clock);
    endtask

    outs_t      o;
    logic [7:0] a_w;
    logic       ovf_w;
    int         strobe_cnt;

    initial begin
        // strobes: {sa, sb, so, sm, ovf}
        //   rst  key    memIn res     A     B     mem   op  st     strobes
        add(1, 4'h0, 0,   0,      0,    0,    0,    0, 2'd0, 5'b00000);
        add(0, 4'h4, 0,   0,      4,    0,    0,    0, 2'd0, 5'b10000);
        add(0, 4'h2, 0,   0,      42,   0,    0,    0, 2'd0, 5'b10000);
        add(0, 4'h7, 0,   0,      42,   0,    0,    0, 2'd0, 5'b00001);
        add(0, 4'hA, 0,   0,      0,    0,    0,    0, 2'd0, 5'b10000);
        add(0, 4'h9, 0,   0,      9,    0,    0,    0, 2'd0, 5'b10000);
        add(0, 4'hC, 0,   0,      9,    0,    0,    0, 2'd1, 5'b01100);
        add(0, 4'h3, 0,   0,      9,    3,    0,    0, 2'd1, 5'b01000);
        add(0, 4'hB, 0,   0,      9,    3,    0,    1, 2'd1, 5'b00100);
        add(0, 4'hD, 0,   0,      9,    3,    0,    1, 2'd2, 5'b00000);
        add(0, 4'hE, 0,   6,      9,    3,    6,    1, 2'd2, 5'b00010);
`ifdef CALC_OP_CHAIN_EN
        add(0, 4'hC, 0,   12,     12,   0,    6,    0, 2'd1, 5'b11100);
`else
        add(0, 4'hC, 0,   12,     9,    3,    6,    1, 2'd2, 5'b00000);
`endif
        add(1, 4'h0, 0,   0,      0,    0,    0,    0, 2'd0, 5'b00000);
        add(0, 4'h1, 0,   0,      1,    0,    0,    0, 2'd0, 5'b10000);
        add(0, 4'hF, 200, 0,      200,  0,    0,    0, 2'd0, 5'b10000);
        add(0, 4'h5, 200, 0,      200,  0,    0,    0, 2'd0, 5'b00001);
        add(0, 4'hE, 0,   0,      200,  0,    200,  0, 2'd0, 5'b00010);
        add(0, 4'hB, 0,   0,      200,  0,    200,  1, 2'd1, 5'b01100);
        add(0, 4'hF, 77,  0,      200,  77,   200,  1, 2'd1, 5'b01000);
        add(0, 4'h1, 77,  0,      200,  77,   200,  1, 2'd1, 5'b00001);
        add(0, 4'hA, 0,   0,      200,  0,    200,  1, 2'd1, 5'b01000);
        add(0, 4'h8, 0,   0,      200,  8,    200,  1, 2'd1, 5'b01000);
        add(0, 4'hE, 0,   0,      200,  8,    8,    1, 2'd1, 5'b00010);
        add(0, 4'hC, 0,   0,      200,  8,    8,    0, 2'd1, 5'b00100);
        add(0, 4'hD, 0,   0,      200,  8,    8,    0, 2'd2, 5'b00000);
        add(0, 4'hA, 0,   0,      200,  8,    8,    0, 2'd2, 5'b00000);
        add(0, 4'h6, 0,   0,      6,    0,    8,    0, 2'd0, 5'b11000);
        add(0, 4'h5, 0,   0,      65,   0,    8,    0, 2'd0, 5'b10000);
        add(0, 4'hD, 0,   0,      65,   0,    8,    0, 2'd0, 5'b00000);
        add(0, 4'hC, 0,   0,      65,   0,    8,    0, 2'd1, 5'b01100);
        add(0, 4'hD, 0,   0,      65,   0,    8,    0, 2'd2, 5'b00000);
        add(0, 4'hF, 33,  0,      33,   0,    8,    0, 2'd0, 5'b11000);

        foreach (vecs[i]) begin
            memoryIn = vecs[i].mem_in;
            result   = vecs[i].res;
            if (vecs[i].rst) begin
                do_reset();
                o = observe();
            end else begin
                press(vecs[i].key, o, a_w, ovf_w);
            end
            check($sformatf("vec%0d", i), 32'(o), 32'(vecs[i].exp));
        end
        memoryIn = 8'h00;
        result   = 8'h00;

        // Strobe lasts exactly one cycle.
        do_reset();
        press(4'h4, o, a_w, ovf_w);
        check("strobe_high", 32'(o.sa), 32'd1);
        check("strobe_low_next", 32'(signedNumberA), 32'd0);

        // Wider digit limit: 256 exceeds the 8-bit range, 255 fits.
        do_reset();
        press(4'h2, o, a_w, ovf_w);
        press(4'h5, o, a_w, ovf_w);
        check("max3_a25", 32'(a_w), 32'd25);
        press(4'h6, o, a_w, ovf_w);
        check("max3_256_a", 32'(a_w), 32'd25);
        check("max3_256_ovf", 32'(ovf_w), 32'd1);
        press(4'hA, o, a_w, ovf_w);
        press(4'h2, o, a_w, ovf_w);
        press(4'h5, o, a_w, ovf_w);
        press(4'h5, o, a_w, ovf_w);
        check("max3_a255", 32'(a_w), 32'd255);
        check("max3_255_ovf", 32'(ovf_w), 32'd0);

        // Ready held high for 20 cycles produces a single action.
        do_reset();
        strobe_cnt = 0;
        @(negedge Clock);
        ready = 1'b1;
        tecla = 4'h5;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clock);
            strobe_cnt += int'(signedNumberA);
        end
        ready = 1'b0;
        @(negedge Clock);
        check("hold_strobes", 32'(strobe_cnt), 32'd1);
        check("hold_a", 32'(numberA), 32'd5);

        // Clear during operand B entry discards everything.
        do_reset();
        @(negedge Clock);
        check("clearout_drop", 32'(clearOut), 32'd0);
        press(4'h9, o, a_w, ovf_w);
        press(4'hC, o, a_w, ovf_w);
        press(4'h3, o, a_w, ovf_w);
        check("pre_clear_b", 32'(numberB), 32'd3);
        @(negedge Clock);
        clearIn = 1'b1;
        ready   = 1'b1;
        tecla   = 4'h7;
        @(negedge Clock);
        clearIn = 1'b0;
        ready   = 1'b0;
        check("clear_outs", 32'(observe()), 32'd0);
        check("clear_clearout", 32'(clearOut), 32'd1);
        check("clear_readyout", 32'(readyOut), 32'd0);
        @(negedge Clock);
        check("clearout_low", 32'(clearOut), 32'd0);

        // readyOut is ready delayed by one cycle.
        @(negedge Clock);
        ready = 1'b1;
        tecla = 4'h1;
        @(negedge Clock);
        check("readyout_high", 32'(readyOut), 32'd1);
        ready = 1'b0;
        @(negedge Clock);
        check("readyout_low", 32'(readyOut), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Parametrised keypad-to-ALU sequencer for the calculator datapath, successor to the single-digit operand controller. Accepts one 4-bit key code per `ready` rising edge, builds multi-digit decimal operands of configurable width, selects add/sub, handles memory save/recall, clear-entry and optional result chaining. It drives operands and one-cycle update strobes to the adder/subtractor and memory blocks and reads back `result` and `memoryIn`.

## Interface
- `WIDTH`, 8: operand/result/memory width in bits.
- `MAX_DIGITS`, 2: maximum decimal digits per typed operand (1..4).

Ports:
- `Clock` in 1: single clock; all logic on rising edge.
- `clearIn` in 1: reset, synchronous, active-high.
- `ready` in 1: key-valid level from keypad scanner; may stay high many cycles.
- `tecla` in 4: key code (0-9 digit, 1010 CE, 1011 SUB, 1100 ADD, 1101 IGUAL, 1110 SAVE, 1111 RECOVERY).
- `memoryIn` in WIDTH: stored memory value.
- `result` in WIDTH: ALU result.
- `memoryOut` out WIDTH: value to store; valid with `signedMemory`.
- `numberA`, `numberB` out WIDTH: operands.
- `operation` out 1: 0 add, 1 sub.
- `signedMemory`, `signedNumberA`, `signedNumberB`, `signedOperation` out 1: one-cycle update strobes.
- `overflow` out 1: one-cycle pulse, digit rejected.
- `clearOut` out 1: high the cycle after any cycle `clearIn` was high.
- `readyOut` out 1: `ready` delayed one cycle.
- `estate` out 2: current state.

## Operation
- Reset: state VALUE_A, all operands/memoryOut 0, `operation` 0, digit counters 0, all strobes/`overflow` 0, `readyOut` 0, `clearOut` 1 next cycle. Reset overrides any key in the same cycle.
- Key accepted only when `ready`=1 and registered previous `ready`=0; one key per press.
- States: VALUE_A=00, VALUE_B=01, VALUE_IGUAL=10; 11 illegal -> VALUE_A next cycle, no strobes.
- Digit entry (A in VALUE_A, B in VALUE_B): first digit after entry replaces operand; next digits: value*10+d computed at WIDTH+4 bits. Accept if count<MAX_DIGITS and result ≤ 2^WIDTH-1 -> update, count+1, strobe. Otherwise operand unchanged, `overflow` pulse.
- CE: current operand <= 0, count 0, strobe. Ignored in VALUE_IGUAL.
- SAVE: `memoryOut` <= A (VALUE_A), B (VALUE_B), `result` (VALUE_IGUAL); `signedMemory` pulse.
- RECOVERY: VALUE_A/VALUE_B: current operand <= `memoryIn`, count <= MAX_DIGITS (locked until CE), strobe. VALUE_IGUAL: A <= `memoryIn`, B <= 0, both strobes, -> VALUE_A.
- ADD/SUB: VALUE_A: `operation` set, `signedOperation`, B <= 0 with strobe, B count 0, -> VALUE_B. VALUE_B: `operation` replaced, `signedOperation`, B untouched. VALUE_IGUAL: see Configuration.
- IGUAL: VALUE_B -> VALUE_IGUAL, no strobes; ignored elsewhere.
- Digit in VALUE_IGUAL: A <= digit (count 1), B <= 0, both strobes, -> VALUE_A.

## Timing
- Key at rising edge n (ready first seen high) -> operands, strobes, `estate` updated at edge n+1; strobes high exactly one cycle.
- `readyOut` = `ready` delayed one cycle; independent of state.
- Holding `ready` high: no further action until it returns low for ≥1 cycle.
- `clearIn` mid-entry: partial operand discarded, no strobes that cycle.

## Configuration
- `CALC_OP_CHAIN_EN` defined: ADD/SUB in VALUE_IGUAL -> A <= `result` (count locked at MAX_DIGITS), `operation` set, B <= 0; `signedNumberA`, `signedNumberB`, `signedOperation` pulse; -> VALUE_B.
- Undefined: ADD/SUB in VALUE_IGUAL ignored, no strobes, state held.

## Test plan
- Reset, keys 4,2 -> A=42, two `signedNumberA` pulses; third digit 7 -> A=42, `overflow` pulse.
- WIDTH=8, MAX_DIGITS=3: keys 2,5,6 -> A=25, third digit rejected (256>255), `overflow`; keys CE,2,5,5 -> A=255.
- 9, ADD, 3, SUB, IGUAL -> A=9, B=3, `operation`=1, `estate`=10; SAVE with `result`=6 -> `memoryOut`=6, `signedMemory` one cycle.
- `ready` held high 20 cycles with key 5 -> exactly one strobe, A=5.
- VALUE_IGUAL, `result`=12, ADD: with `CALC_OP_CHAIN_EN` A=12, `estate`=01; without, no change.
- `clearIn` during VALUE_B entry -> all outputs 0, `estate`=00, `clearOut` 1 next cycle.
